// File: rtl/game_state_ctl.sv
// Round/score controller: debounces the start button, tracks lives, times the win
// screen, and commits frame-stable mode flags for the frame drawer.
module game_state_ctl #(
  parameter int LIVES           = 3,
  parameter int WIN_FRAMES      = 180,
  parameter int DEBOUNCE_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       donkey_hit,
  input  logic       kong_hit,
  output logic       game_en,
  output logic       donkey_win,
  output logic       kong_win,
  output logic       round_start,
  output logic [2:0] donkey_lives,
  output logic [2:0] kong_lives
);

  localparam int          DW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
  localparam logic [7:0]  WIN_LAST   = 8'(WIN_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_MENU       = 2'd0,
    ST_GAME       = 2'd1,
    ST_DONKEY_WIN = 2'd2,
    ST_KONG_WIN   = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [1:0]      sync_r;
  logic [DW-1:0]   deb_cnt_r;
  logic            deb_r, deb_d_r;
  logic            start_press_s;
  logic [7:0]      frame_cnt_r, frame_cnt_nxt_s;
  logic [2:0]      d_lives_r, k_lives_r, d_lives_nxt_s, k_lives_nxt_s;
  logic            round_start_r, round_start_nxt_s;
  logic            d_dead_s, k_dead_s;
  logic            game_en_r, donkey_win_r, kong_win_r;

  // Start button: 2-flop synchroniser, then a level must differ for the full count to be accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r    <= 2'b00;
      deb_cnt_r <= {DW{1'b0}};
      deb_r     <= 1'b0;
      deb_d_r   <= 1'b0;
    end else begin
      sync_r  <= {sync_r[0], start_btn};
      deb_d_r <= deb_r;
      if (sync_r[1] != deb_r) begin
        if (deb_cnt_r == DEB_LAST) begin
          deb_r     <= sync_r[1];
          deb_cnt_r <= {DW{1'b0}};
        end else begin
          deb_cnt_r <= deb_cnt_r + DW'(1);
        end
      end else begin
        deb_cnt_r <= {DW{1'b0}};
      end
    end
  end

  assign start_press_s = deb_r & ~deb_d_r;

  // Next state, lives and win-screen frame count
  always_comb begin
    state_nxt_s       = state_r;
    d_lives_nxt_s     = d_lives_r;
    k_lives_nxt_s     = k_lives_r;
    round_start_nxt_s = 1'b0;
    frame_cnt_nxt_s   = frame_cnt_r;
    d_dead_s          = 1'b0;
    k_dead_s          = 1'b0;
    case (state_r)
      ST_MENU: begin
        frame_cnt_nxt_s = 8'd0;
        if (start_press_s) begin
          state_nxt_s       = ST_GAME;
          d_lives_nxt_s     = LIVES_INIT;
          k_lives_nxt_s     = LIVES_INIT;
          round_start_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_MENU;
        end
      end
      ST_GAME: begin
        frame_cnt_nxt_s = 8'd0;
        if (donkey_hit && (d_lives_r != 3'd0)) begin
          d_lives_nxt_s = d_lives_r - 3'd1;
        end else begin
          d_lives_nxt_s = d_lives_r;
        end
        if (kong_hit && (k_lives_r != 3'd0)) begin
          k_lives_nxt_s = k_lives_r - 3'd1;
        end else begin
          k_lives_nxt_s = k_lives_r;
        end
        d_dead_s = donkey_hit && (d_lives_nxt_s == 3'd0);
        k_dead_s = kong_hit && (k_lives_nxt_s == 3'd0);
        // Simultaneous knockout is a draw and goes straight back to the menu
        if (d_dead_s && k_dead_s) begin
          state_nxt_s = ST_MENU;
        end else if (d_dead_s) begin
          state_nxt_s = ST_KONG_WIN;
        end else if (k_dead_s) begin
          state_nxt_s = ST_DONKEY_WIN;
        end else begin
          state_nxt_s = ST_GAME;
        end
      end
      ST_DONKEY_WIN, ST_KONG_WIN: begin
        if (start_press_s) begin
          state_nxt_s     = ST_MENU;
          frame_cnt_nxt_s = 8'd0;
        end else if (frame_tick) begin
          if (frame_cnt_r == WIN_LAST) begin
            state_nxt_s     = ST_MENU;
            frame_cnt_nxt_s = 8'd0;
          end else begin
            frame_cnt_nxt_s = frame_cnt_r + 8'd1;
          end
        end else begin
          frame_cnt_nxt_s = frame_cnt_r;
        end
      end
      default: begin
        state_nxt_s     = ST_MENU;
        frame_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Per-clock state, lives and round_start registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_MENU;
      frame_cnt_r   <= 8'd0;
      d_lives_r     <= LIVES_INIT;
      k_lives_r     <= LIVES_INIT;
      round_start_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      frame_cnt_r   <= frame_cnt_nxt_s;
      d_lives_r     <= d_lives_nxt_s;
      k_lives_r     <= k_lives_nxt_s;
      round_start_r <= round_start_nxt_s;
    end
  end

  // Mode flags sample the current (pre-change) state only on frame_tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      game_en_r    <= 1'b0;
      donkey_win_r <= 1'b0;
      kong_win_r   <= 1'b0;
    end else if (frame_tick) begin
      game_en_r    <= (state_r == ST_GAME);
      donkey_win_r <= (state_r == ST_DONKEY_WIN);
      kong_win_r   <= (state_r == ST_KONG_WIN);
    end
  end

  assign game_en      = game_en_r;
  assign donkey_win   = donkey_win_r;
  assign kong_win     = kong_win_r;
  assign round_start  = round_start_r;
  assign donkey_lives = d_lives_r;
  assign kong_lives   = k_lives_r;

endmodule
